// File: rtl/mul_exec.sv
// Multi-cycle execute-stage controller for the 16-bit multiply path.
// Operands are held on an external array multiplier for SETTLE_CYC cycles before capture.
module mul_exec #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RD_W       = 3,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_rs1,
   input  logic [DATA_W-1:0] in_rs2,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              flush,
   output logic [DATA_W-1:0] mul_rs1,
   output logic [DATA_W-1:0] mul_rs2,
   input  logic [DATA_W-1:0] mul_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              busy
);

   localparam int unsigned CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rs1_q, rs1_d;
   logic [DATA_W-1:0] rs2_q, rs2_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [RD_W-1:0]   out_rd_q, out_rd_d;

   logic accept;
   logic zero_op;

   // rst_n is folded in so issue never sees ready while the block is held in reset.
   assign in_ready = !flush && rst_n &&
                     ((state_q == StIdle) || ((state_q == StDone) && out_ready));
   assign accept   = in_valid && in_ready;
   assign zero_op  = (in_rs1 == '0) || (in_rs2 == '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      data_d   = data_q;
      out_rd_d = out_rd_q;

      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StIdle;
            end
            StSettle: begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q <= CNT_W'(1)) begin
                  data_d   = mul_prod;
                  out_rd_d = rd_q;
                  cnt_d    = '0;
                  state_d  = StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_d = StIdle;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase

         // Accept is only possible from IDLE or a completing DONE, so it overrides both.
         if (accept) begin
            rs1_d = in_rs1;
            rs2_d = in_rs2;
            rd_d  = in_rd;
            cnt_d = CNT_LOAD;
            if (zero_op) begin
               data_d   = '0;
               out_rd_d = in_rd;
               state_d  = StDone;
            end else begin
               state_d = StSettle;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         data_q   <= '0;
         out_rd_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         data_q   <= data_d;
         out_rd_q <= out_rd_d;
      end
   end

   assign mul_rs1   = rs1_q;
   assign mul_rs2   = rs2_q;
   assign out_data  = data_q;
   assign out_rd    = out_rd_q;
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);

`ifndef SYNTHESIS
   a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data) && $stable(out_rd)));
   a_ops_hold : assert property (@(posedge clk) disable iff (!rst_n)
      !accept |=> ($stable(mul_rs1) && $stable(mul_rs2)));
`endif

endmodule

// File: tb/tb_mul_exec.sv
// Randomised + directed bench for mul_exec: a driver queues expected results on accept,
// a negedge monitor runs a latency-level reference model and scores the DUT.
module tb_mul_exec;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned RD_W       = 3;
   localparam int unsigned SETTLE_CYC = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_rs1;
   logic [DATA_W-1:0] in_rs2;
   logic [RD_W-1:0]   in_rd;
   logic              flush;
   logic [DATA_W-1:0] mul_rs1;
   logic [DATA_W-1:0] mul_rs2;
   logic [DATA_W-1:0] mul_prod;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [RD_W-1:0]   out_rd;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // {rd, product} per accepted op, oldest first
   logic [RD_W+DATA_W-1:0] sb[$];

   // reference model: 0 idle, 1 settling, 2 result presented
   int                m_phase = 0;
   int                m_left  = 0;
   logic [DATA_W-1:0] m_a     = '0;
   logic [DATA_W-1:0] m_b     = '0;

   always #5 clk = ~clk;

   // Behavioural array multiplier (low half of the product).
   assign mul_prod = mul_rs1 * mul_rs2;

   mul_exec #(
      .DATA_W    (DATA_W),
      .RD_W      (RD_W),
      .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_rs1   (in_rs1),
      .in_rs2   (in_rs2),
      .in_rd    (in_rd),
      .flush    (flush),
      .mul_rs1  (mul_rs1),
      .mul_rs2  (mul_rs2),
      .mul_prod (mul_prod),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_rd   (out_rd),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [RD_W-1:0] rd, input logic ordy, input logic fl,
                        output logic acc);
      logic [31:0] prod;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_rs1    = a;
      in_rs2    = b;
      in_rd     = rd;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      acc = rst_n && in_valid && in_ready;
      if (acc) begin
         prod = 32'(a) * 32'(b);
         sb.push_back({rd, prod[DATA_W-1:0]});
      end
   endtask

   task automatic idle(input int n, input logic ordy);
      logic acc;
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, ordy, 1'b0, acc);
   endtask

   task automatic issue(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [RD_W-1:0] rd, input logic ordy);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         drive(1'b1, a, b, rd, ordy, 1'b0, acc);
         tries++;
      end
      if (!acc) begin
         errors++;
         $display("FAIL issue_timeout actual=not_accepted required=accepted at %0t", $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] pick_operand();
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return '0;
         1:       return 16'hFFFF;
         2:       return 16'h0100;
         default: return DATA_W'($urandom);
      endcase
   endfunction

   // Monitor: compares DUT against the model, then advances the model over the coming edge.
   always @(negedge clk) begin
      logic exp_rdy;
      logic hs;
      logic acc;
      if (!rst_n) begin
         chk("rst_in_ready", 32'(in_ready), 0);
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_out_data", 32'(out_data), 0);
         chk("rst_out_rd", 32'(out_rd), 0);
         chk("rst_mul_ops", {mul_rs1, mul_rs2}, 0);
         m_phase = 0;
         m_left  = 0;
         sb.delete();
      end else begin
         exp_rdy = !flush && (m_phase == 0 || (m_phase == 2 && out_ready));
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
         chk("busy", 32'(busy), 32'(m_phase != 0));
         if (m_phase == 1) chk("mul_ops_stable", {mul_rs1, mul_rs2}, {m_a, m_b});
         if (m_phase == 2) begin
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_empty actual=valid_result required=no_expected_entry at %0t",
                        $time);
            end else begin
               chk("out_data", 32'(out_data), 32'(sb[0][DATA_W-1:0]));
               chk("out_rd", 32'(out_rd), 32'(sb[0][RD_W+DATA_W-1:DATA_W]));
            end
         end
         if (flush) begin
            m_phase = 0;
            sb.delete();
         end else begin
            hs  = (m_phase == 2) && out_ready;
            acc = in_valid && exp_rdy;
            if (hs && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
               m_a = in_rs1;
               m_b = in_rs2;
               if (in_rs1 == 0 || in_rs2 == 0) begin
                  m_phase = 2;
               end else begin
                  m_phase = 1;
                  m_left  = SETTLE_CYC;
               end
            end else if (m_phase == 1) begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end else if (hs) begin
               m_phase = 0;
            end
         end
      end
   end

   initial begin
      logic              acc;
      logic              pend_v;
      logic [DATA_W-1:0] pa, pb;
      logic [RD_W-1:0]   prd;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_rs1    = '0;
      in_rs2    = '0;
      in_rd     = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // basic, wraparound, truncation (full settle path), zero fast path
      issue(16'h0003, 16'h0005, 3'd5, 1'b1);
      idle(4, 1'b1);
      issue(16'hFFFF, 16'hFFFF, 3'd1, 1'b1);
      issue(16'h0100, 16'h0100, 3'd3, 1'b1);
      issue(16'h0000, 16'h1234, 3'd2, 1'b1);
      idle(3, 1'b1);

      // backpressure for 5 cycles in DONE, then handshake + accept in the same cycle
      issue(16'h0009, 16'h0009, 3'd4, 1'b0);
      idle(SETTLE_CYC + 5, 1'b0);
      issue(16'h0002, 16'h0007, 3'd6, 1'b1);
      idle(4, 1'b1);

      // flush one cycle into SETTLE, then a normal op
      issue(16'h0005, 16'h0005, 3'd1, 1'b1);
      drive(1'b1, 16'h0011, 16'h0011, 3'd7, 1'b1, 1'b1, acc);
      issue(16'h0006, 16'h0006, 3'd2, 1'b1);
      idle(4, 1'b1);

      // flush while result presented and out_ready high
      issue(16'h0007, 16'h0003, 3'd3, 1'b0);
      idle(SETTLE_CYC, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 1'b1, acc);
      idle(3, 1'b1);

      // asynchronous reset mid-SETTLE
      issue(16'h1111, 16'h0003, 3'd5, 1'b1);
      idle(1, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_ops", {mul_rs1, mul_rs2}, 0);
      chk("async_rst_out", {out_rd, out_data}, 0);
      idle(2, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      issue(16'h0004, 16'h0004, 3'd5, 1'b1);
      idle(4, 1'b1);

      // randomised traffic; an un-accepted offer is held until taken or flushed
      pend_v = 1'b0;
      pa     = '0;
      pb     = '0;
      prd    = '0;
      for (int i = 0; i < 600; i++) begin
         logic fl;
         if (!pend_v) begin
            pend_v = ($urandom_range(0, 9) < 7);
            pa     = pick_operand();
            pb     = pick_operand();
            prd    = RD_W'($urandom);
         end
         fl = ($urandom_range(0, 39) == 0);
         drive(pend_v, pa, pb, prd, ($urandom_range(0, 9) < 7), fl, acc);
         if (acc || fl) pend_v = 1'b0;
      end

      idle(SETTLE_CYC + 4, 1'b1);
      chk("sb_drained", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
